// File: rtl/cde_pkg.sv
// Shared types and default configuration for the cipher dispatch engine.
package cde_pkg;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CDE_NUM_CORES      = 3;
  localparam int CDE_DATA_W         = 64;
  localparam int CDE_KEY_W          = 168;
  localparam int CDE_FIFO_DEPTH     = 4;
  localparam int CDE_TIMEOUT_CYCLES = 1024;
  localparam int CDE_SEL_W          = sel_width(CDE_NUM_CORES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT
  } cde_state_t;

  // Request layout at the default widths; the engine uses the same field order.
  typedef struct packed {
    logic [CDE_SEL_W-1:0]  sel;
    logic                  decrypt;
    logic [CDE_KEY_W-1:0]  key;
    logic [CDE_DATA_W-1:0] data;
  } cde_req_t;

endpackage

// File: rtl/cde_fifo.sv
// Synchronous request FIFO; a push against a full queue is dropped even if a pop occurs.
module cde_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/cipher_dispatch_engine.sv
// Queues cipher requests and dispatches them one at a time to external cores.
// Optional WAIT watchdog enabled by defining CIPHER_DISPATCH_TIMEOUT_EN.
module cipher_dispatch_engine
  import cde_pkg::*;
#(
  parameter int NUM_CORES  = CDE_NUM_CORES,
  parameter int DATA_W     = CDE_DATA_W,
  parameter int KEY_W      = CDE_KEY_W,
  parameter int FIFO_DEPTH = CDE_FIFO_DEPTH,
`ifdef CIPHER_DISPATCH_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = CDE_TIMEOUT_CYCLES,
`endif
  localparam int SEL_W = sel_width(NUM_CORES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  input  logic [KEY_W-1:0]            in_key,
  input  logic [SEL_W-1:0]            in_sel,
  input  logic                        in_decrypt,
  output logic [NUM_CORES-1:0]        core_start,
  output logic [DATA_W-1:0]           core_data,
  output logic [KEY_W-1:0]            core_key,
  output logic                        core_decrypt,
  input  logic [NUM_CORES-1:0]        core_done,
  input  logic [NUM_CORES*DATA_W-1:0] core_result,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [SEL_W-1:0]            out_sel,
  output logic                        out_err
);

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic              decrypt;
    logic [KEY_W-1:0]  key;
    logic [DATA_W-1:0] data;
  } req_t;

  localparam int FIFO_W = $bits(req_t);

  cde_state_t               state, state_nxt;
  req_t                     req_q, fifo_rd;
  logic [DATA_W-1:0]        res_q;
  logic                     err_q;
  logic                     fifo_full, fifo_empty, fifo_pop;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                     unused_count;
  logic                     sel_valid, done_hit, timeout_hit;
  logic [DATA_W-1:0]        sel_result;

  cde_fifo #(.WIDTH(FIFO_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (in_valid),
    .pop     (fifo_pop),
    .wr_data ({in_sel, in_decrypt, in_key, in_data}),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign unused_count = ^fifo_count;

  // Only the selected core's done/result are visible; out-of-range selects match nothing.
  always_comb begin
    sel_valid  = 1'b0;
    done_hit   = 1'b0;
    sel_result = '0;
    core_start = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (req_q.sel == SEL_W'(i)) begin
        sel_valid     = 1'b1;
        done_hit      = core_done[i];
        sel_result    = core_result[i*DATA_W +: DATA_W];
        core_start[i] = (state == ST_ISSUE);
      end
    end
  end

`ifdef CIPHER_DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;

  // Held at zero outside WAIT, so every WAIT entry starts a fresh count.
  always_ff @(posedge clk) begin
    if (reset || state != ST_WAIT) wait_cnt <= '0;
    else                           wait_cnt <= wait_cnt + TW'(1);
  end

  assign timeout_hit = (state == ST_WAIT) && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: state_nxt = sel_valid ? ST_WAIT : ST_OUT;
      ST_WAIT:  if (done_hit || timeout_hit) state_nxt = ST_OUT;
      ST_OUT:   if (out_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      req_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && !fifo_empty) req_q <= fifo_rd;
      if (state == ST_ISSUE && !sel_valid) begin
        res_q <= '0;
        err_q <= 1'b1;
      end
      if (state == ST_WAIT) begin
        if (done_hit) begin
          res_q <= sel_result;
          err_q <= 1'b0;
        end else if (timeout_hit) begin
          res_q <= '0;
          err_q <= 1'b1;
        end
      end
    end
  end

  assign in_ready     = !fifo_full;
  assign core_data    = req_q.data;
  assign core_key     = req_q.key;
  assign core_decrypt = req_q.decrypt;
  assign out_valid    = (state == ST_OUT);
  assign out_data     = res_q;
  assign out_sel      = req_q.sel;
  assign out_err      = err_q;

endmodule

// File: tb/tb_cipher_dispatch_engine.sv
// Self-checking bench for cipher_dispatch_engine with an emulated set of cipher cores.
module tb_cipher_dispatch_engine;
  import cde_pkg::*;

  localparam int NC = 3;
  localparam int DW = 64;
  localparam int KW = 168;
  localparam int SW = 2;

  typedef logic [191:0] wide_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid, in_ready, in_decrypt;
  logic [DW-1:0]  in_data;
  logic [KW-1:0]  in_key;
  logic [SW-1:0]  in_sel;
  logic [NC-1:0]  core_start, core_done;
  logic [DW-1:0]  core_data;
  logic [KW-1:0]  core_key;
  logic           core_decrypt;
  logic [NC*DW-1:0] core_result;
  logic           out_valid, out_ready, out_err;
  logic [DW-1:0]  out_data;
  logic [SW-1:0]  out_sel;

  int total = 0;
  int bad = 0;
  cde_req_t exp_q[$];
  logic auto_core = 1'b0;
  logic spurious_en = 1'b0;
  int delay_max = 0;

  cipher_dispatch_engine #(
    .NUM_CORES(NC), .DATA_W(DW), .KEY_W(KW), .FIFO_DEPTH(4)
`ifdef CIPHER_DISPATCH_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
    .in_sel(in_sel), .in_decrypt(in_decrypt),
    .core_start(core_start), .core_data(core_data), .core_key(core_key),
    .core_decrypt(core_decrypt), .core_done(core_done), .core_result(core_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // What an attached core would compute; the engine itself never sees this formula.
  function automatic logic [DW-1:0] core_fn(input int idx, input logic [DW-1:0] d,
                                            input logic [KW-1:0] k, input logic dec);
    return {d[31:0], d[63:32]} ^ k[DW-1:0] ^ (DW'(idx + 1) * 64'h0101_0101_0101_0101)
           ^ {63'b0, dec};
  endfunction

  function automatic logic [KW-1:0] randKey();
    logic [191:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[KW-1:0];
  endfunction

  function automatic logic [DW-1:0] randData();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [NC*DW-1:0] randResult();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input wide_t observed, input wide_t expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic reportTimeout(input string tag);
    total++;
    bad++;
    $error("[TB] FAIL %s: observed=bound expired expected=event", tag);
  endtask

  task automatic applyStimulus(input logic [SW-1:0] sel, input logic dec,
                               input logic [KW-1:0] key, input logic [DW-1:0] data);
    cde_req_t r;
    r.sel = sel; r.decrypt = dec; r.key = key; r.data = data;
    in_valid = 1'b1; in_sel = sel; in_decrypt = dec; in_key = key; in_data = data;
    for (int c = 0; c < 64; c++) begin
      if (in_ready) begin
        step(1);
        in_valid = 1'b0;
        exp_q.push_back(r);
        return;
      end
      step(1);
    end
    in_valid = 1'b0;
    reportTimeout("push");
  endtask

  task automatic waitStart(input string tag);
    for (int c = 0; c < 20; c++) begin
      if (core_start != '0) return;
      step(1);
    end
    reportTimeout(tag);
  endtask

  task automatic ackOutput();
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
  endtask

  task automatic compareHead();
    cde_req_t r;
    logic [DW-1:0] ed;
    logic ee;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL unexpected_out: observed=%0h expected=none", out_data);
      return;
    end
    r = exp_q.pop_front();
    if (int'(r.sel) < NC) begin
      ed = core_fn(int'(r.sel), r.data, r.key, r.decrypt);
      ee = 1'b0;
    end else begin
      ed = '0;
      ee = 1'b1;
    end
    checkOutput("out_data", wide_t'(out_data), wide_t'(ed));
    checkOutput("out_sel", wide_t'(out_sel), wide_t'(r.sel));
    checkOutput("out_err", wide_t'(out_err), wide_t'(ee));
  endtask

  task automatic drainAll(input int budget);
    int extra;
    extra = 0;
    out_ready = 1'b1;
    for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
      if (out_valid) compareHead();
      step(1);
    end
    if (exp_q.size() != 0) reportTimeout("drain");
    for (int c = 0; c < 4; c++) begin
      if (out_valid) extra++;
      step(1);
    end
    checkOutput("drain_extra", wide_t'(extra), wide_t'(0));
    out_ready = 1'b0;
  endtask

  // Core emulator: answers the started core after a random delay, optionally
  // pulsing other cores' done lines with junk in between.
  initial begin
    int idx, dly, other;
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic dec;
    forever begin
      @(negedge clk);
      if (auto_core && core_start != '0) begin
        idx = 0;
        for (int i = 0; i < NC; i++) if (core_start[i]) idx = i;
        d = core_data; k = core_key; dec = core_decrypt;
        dly = (delay_max == 0) ? 0 : int'($urandom_range(0, delay_max));
        @(posedge clk);
        #1;
        for (int j = 0; j < dly; j++) begin
          core_done = '0;
          if (spurious_en && $urandom_range(0, 1) == 1) begin
            other = (idx + 1 + int'($urandom_range(0, NC - 2))) % NC;
            core_done[other] = 1'b1;
            core_result = randResult();
          end
          @(posedge clk);
          #1;
        end
        core_result = randResult();
        core_result[idx*DW +: DW] = core_fn(idx, d, k, dec);
        core_done = '0;
        core_done[idx] = 1'b1;
        @(posedge clk);
        #1;
        core_done = '0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed=still running expected=finished");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    logic [NC-1:0] start_seen;
    logic [DW-1:0] held_data;
    logic hold_pending, valid_seen;
    logic [KW-1:0] key1;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_key = '0; in_sel = '0;
    in_decrypt = 1'b0; core_done = '0; core_result = '0; out_ready = 1'b0;

    // Reset values, both while reset is held and just after release.
    step(3);
    checkOutput("rst_in_ready", wide_t'(in_ready), wide_t'(1'b1));
    checkOutput("rst_core_start", wide_t'(core_start), wide_t'(0));
    checkOutput("rst_out_valid", wide_t'(out_valid), wide_t'(1'b0));
    checkOutput("rst_out_data", wide_t'(out_data), wide_t'(0));
    checkOutput("rst_out_sel", wide_t'(out_sel), wide_t'(0));
    checkOutput("rst_out_err", wide_t'(out_err), wide_t'(1'b0));
    reset = 1'b0;
    step(1);
    checkOutput("post_rst_in_ready", wide_t'(in_ready), wide_t'(1'b1));
    checkOutput("post_rst_out_valid", wide_t'(out_valid), wide_t'(1'b0));

    // Single operation on core 1, done after ten WAIT cycles.
    $display("[TB] single operation on core 1");
    key1 = randKey();
    applyStimulus(2'd1, 1'b1, key1, 64'h0123456789ABCDEF);
    checkOutput("lat_idle_no_start", wide_t'(core_start), wide_t'(0));
    step(1);
    checkOutput("issue_start", wide_t'(core_start), wide_t'(3'b010));
    checkOutput("issue_data", wide_t'(core_data), wide_t'(64'h0123456789ABCDEF));
    checkOutput("issue_key", wide_t'(core_key), wide_t'(key1));
    checkOutput("issue_decrypt", wide_t'(core_decrypt), wide_t'(1'b1));
    core_done = 3'b010;
    core_result = {64'h0, 64'hBAD0BAD0BAD0BAD0, 64'h0};
    step(1);
    core_done = '0;
    checkOutput("wait_start_pulse", wide_t'(core_start), wide_t'(0));
    step(9);
    checkOutput("issue_done_ignored", wide_t'(out_valid), wide_t'(1'b0));
    checkOutput("wait_data_stable", wide_t'(core_data), wide_t'(64'h0123456789ABCDEF));
    core_done = 3'b010;
    core_result = {64'h0, 64'hDEADBEEF00000000, 64'h0};
    step(1);
    core_done = '0;
    core_result = '0;
    checkOutput("single_valid", wide_t'(out_valid), wide_t'(1'b1));
    checkOutput("single_data", wide_t'(out_data), wide_t'(64'hDEADBEEF00000000));
    checkOutput("single_sel", wide_t'(out_sel), wide_t'(2'd1));
    checkOutput("single_err", wide_t'(out_err), wide_t'(1'b0));
    step(3);
    checkOutput("single_hold_valid", wide_t'(out_valid), wide_t'(1'b1));
    checkOutput("single_hold_data", wide_t'(out_data), wide_t'(64'hDEADBEEF00000000));
    ackOutput();
    checkOutput("single_released", wide_t'(out_valid), wide_t'(1'b0));
    exp_q.delete();

    // Done pulses from a core other than the selected one are ignored.
    $display("[TB] spurious done from core 2");
    applyStimulus(2'd0, 1'b0, randKey(), randData());
    waitStart("spur_start");
    checkOutput("spur_start_bit", wide_t'(core_start), wide_t'(3'b001));
    step(1);
    core_done = 3'b100;
    core_result = {64'h2222222222222222, 64'h1111111111111111, 64'h5555AAAA5555AAAA};
    step(2);
    core_done = '0;
    checkOutput("spur_ignored", wide_t'(out_valid), wide_t'(1'b0));
    core_done = 3'b001;
    step(1);
    core_done = '0;
    checkOutput("spur_valid", wide_t'(out_valid), wide_t'(1'b1));
    checkOutput("spur_data", wide_t'(out_data), wide_t'(64'h5555AAAA5555AAAA));
    ackOutput();
    exp_q.delete();

    // Out-of-range select completes with an error and starts no core.
    $display("[TB] invalid select");
    applyStimulus(2'd3, 1'b0, randKey(), 64'hFFFF0000FFFF0000);
    start_seen = '0;
    valid_seen = 1'b0;
    for (int c = 0; c < 10 && !valid_seen; c++) begin
      start_seen |= core_start;
      valid_seen = out_valid;
      if (!valid_seen) step(1);
    end
    if (!valid_seen) reportTimeout("inv_valid");
    checkOutput("inv_no_start", wide_t'(start_seen), wide_t'(0));
    checkOutput("inv_err", wide_t'(out_err), wide_t'(1'b1));
    checkOutput("inv_data", wide_t'(out_data), wide_t'(0));
    checkOutput("inv_sel", wide_t'(out_sel), wide_t'(2'd3));
    ackOutput();
    exp_q.delete();

    // Backpressure: one in flight plus four buffered fills the engine.
    $display("[TB] backpressure");
    auto_core = 1'b1;
    delay_max = 0;
    for (int n = 0; n < 5; n++) applyStimulus(SW'(n % NC), 1'(n), randKey(), randData());
    checkOutput("bp_full", wide_t'(in_ready), wide_t'(1'b0));
    in_valid = 1'b1; in_sel = 2'd0; in_data = randData();
    for (int c = 0; c < 3; c++) begin
      step(1);
      checkOutput("bp_still_full", wide_t'(in_ready), wide_t'(1'b0));
    end
    in_valid = 1'b0;
    drainAll(100);

    // Random traffic with random core latency, spurious dones and backpressure.
    $display("[TB] random traffic");
    delay_max = 4;
    spurious_en = 1'b1;
    hold_pending = 1'b0;
    held_data = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (hold_pending) begin
        checkOutput("hold_valid", wide_t'(out_valid), wide_t'(1'b1));
        checkOutput("hold_data", wide_t'(out_data), wide_t'(held_data));
      end
      in_valid = ($urandom_range(0, 1) == 1);
      in_sel = SW'($urandom_range(0, 3));
      in_decrypt = 1'($urandom_range(0, 1));
      in_key = randKey();
      in_data = randData();
      out_ready = ($urandom_range(0, 9) < 6);
      if (in_valid && in_ready) begin
        cde_req_t r;
        r.sel = in_sel; r.decrypt = in_decrypt; r.key = in_key; r.data = in_data;
        exp_q.push_back(r);
      end
      if (out_valid && out_ready) compareHead();
      hold_pending = out_valid && !out_ready;
      held_data = out_data;
      step(1);
    end
    in_valid = 1'b0;
    drainAll(400);
    auto_core = 1'b0;
    spurious_en = 1'b0;

    // Reset while waiting on a core; the late done must not revive the request.
    $display("[TB] reset during wait");
    applyStimulus(2'd0, 1'b0, randKey(), randData());
    waitStart("rw_start");
    step(2);
    reset = 1'b1;
    step(1);
    checkOutput("rw_rst_start", wide_t'(core_start), wide_t'(0));
    checkOutput("rw_rst_valid", wide_t'(out_valid), wide_t'(1'b0));
    reset = 1'b0;
    core_done = 3'b001;
    core_result = randResult();
    step(1);
    core_done = '0;
    start_seen = '0;
    valid_seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      start_seen |= core_start;
      valid_seen |= out_valid;
      step(1);
    end
    checkOutput("rw_no_valid", wide_t'(valid_seen), wide_t'(1'b0));
    checkOutput("rw_fifo_empty", wide_t'(start_seen), wide_t'(0));
    checkOutput("rw_in_ready", wide_t'(in_ready), wide_t'(1'b1));
    exp_q.delete();

`ifdef CIPHER_DISPATCH_TIMEOUT_EN
    // Watchdog: no done, so the 17th WAIT cycle is the error output.
    $display("[TB] watchdog timeout");
    applyStimulus(2'd2, 1'b0, randKey(), randData());
    waitStart("to_start");
    step(16);
    checkOutput("to_wait16", wide_t'(out_valid), wide_t'(1'b0));
    step(1);
    checkOutput("to_valid", wide_t'(out_valid), wide_t'(1'b1));
    checkOutput("to_err", wide_t'(out_err), wide_t'(1'b1));
    checkOutput("to_data", wide_t'(out_data), wide_t'(0));
    ackOutput();
    exp_q.delete();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
